// File: rtl/ltl_nfa_monitor_prog_if.sv
// ltl_nfa_monitor_prog_if: config, control, symbol and status bundle of the programmable NFA monitor.
interface ltl_nfa_monitor_prog_if #(
  parameter int SYM_W = 8,
  parameter int N_STATES = 16,
  parameter int N_INTV = 4,
  parameter int CNT_W = 16,
  parameter int IDX_W = $clog2(N_STATES),
  parameter int IV_W = (N_INTV > 1) ? $clog2(N_INTV) : 1,
  parameter int CFG_W = (2*SYM_W+1 > N_STATES) ? 2*SYM_W+1 : N_STATES
);
  logic cfg_valid, cfg_ready;
  logic [2:0] cfg_sel;
  logic [IDX_W-1:0] cfg_ste;
  logic [IV_W-1:0] cfg_intv;
  logic [CFG_W-1:0] cfg_data;
  logic start, stop, sym_valid;
  logic [SYM_W-1:0] sym;
  logic running, halted, report_any, first_rep_vld;
  logic [N_STATES-1:0] active, report;
  logic [CNT_W-1:0] sym_cnt, rep_cnt, first_rep_idx;
  modport master (
    output cfg_valid, cfg_sel, cfg_ste, cfg_intv, cfg_data, start, stop, sym_valid, sym,
    input cfg_ready, running, halted, active, report, report_any, sym_cnt, rep_cnt, first_rep_idx, first_rep_vld
  );
  modport slave (
    input cfg_valid, cfg_sel, cfg_ste, cfg_intv, cfg_data, start, stop, sym_valid, sym,
    output cfg_ready, running, halted, active, report, report_any, sym_cnt, rep_cnt, first_rep_idx, first_rep_vld
  );
endinterface

// File: rtl/ltl_nfa_monitor_prog.sv
// ltl_nfa_monitor_prog: runtime-programmable NFA monitor on a symbol stream with report counting.
// Define MON_REPORT_HALT_EN to stop consuming symbols (HALT) after the first report.
module ltl_nfa_monitor_prog #(
  parameter int SYM_W = 8,
  parameter int N_STATES = 16,
  parameter int N_INTV = 4,
  parameter int CNT_W = 16,
  parameter int IDX_W = $clog2(N_STATES),
  parameter int CFG_W = (2*SYM_W+1 > N_STATES) ? 2*SYM_W+1 : N_STATES
) (
  input logic clk,
  input logic reset,
  ltl_nfa_monitor_prog_if.slave bus
);
  localparam int IV_W = (N_INTV > 1) ? $clog2(N_INTV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;
  state_t state, state_nx;
  logic [N_INTV-1:0] en [N_STATES];
  logic [SYM_W-1:0] lo [N_STATES][N_INTV];
  logic [SYM_W-1:0] hi [N_STATES][N_INTV];
  logic [N_STATES-1:0] adj [N_STATES];
  logic [N_STATES-1:0] start_sod, start_all, rep_mask, active, match, reach, enable, report;
  logic [CNT_W-1:0] sym_cnt, rep_cnt, first_rep_idx;
  logic sod, wr, ste_ok, iv_ok, go, acc, report_any, first_rep_vld;
  assign wr = bus.cfg_valid && state != RUN;
  assign ste_ok = {1'b0, bus.cfg_ste} < (IDX_W+1)'(N_STATES);
  assign iv_ok = {1'b0, bus.cfg_intv} < (IV_W+1)'(N_INTV);
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_STATES; i++) begin
        en[i] <= '0;
        adj[i] <= '0;
      end
      start_sod <= '0;
      start_all <= '0;
      rep_mask <= '0;
    end else if (wr) begin
      if (bus.cfg_sel == 3'd0 && ste_ok && iv_ok) begin
        en[bus.cfg_ste][bus.cfg_intv] <= bus.cfg_data[2*SYM_W];
        lo[bus.cfg_ste][bus.cfg_intv] <= bus.cfg_data[2*SYM_W-1 -: SYM_W];
        hi[bus.cfg_ste][bus.cfg_intv] <= bus.cfg_data[SYM_W-1:0];
      end
      if (bus.cfg_sel == 3'd1 && ste_ok) adj[bus.cfg_ste] <= bus.cfg_data[N_STATES-1:0];
      if (bus.cfg_sel == 3'd2) start_sod <= bus.cfg_data[N_STATES-1:0];
      if (bus.cfg_sel == 3'd3) start_all <= bus.cfg_data[N_STATES-1:0];
      if (bus.cfg_sel == 3'd4) rep_mask <= bus.cfg_data[N_STATES-1:0];
    end
  end
  always_comb begin
    match = '0;
    reach = '0;
    for (int i = 0; i < N_STATES; i++) begin
      for (int k = 0; k < N_INTV; k++)
        if (en[i][k] && bus.sym >= lo[i][k] && bus.sym <= hi[i][k]) match[i] = 1'b1;
      if (active[i]) reach = reach | adj[i];
    end
  end
  assign enable = start_all | ({N_STATES{sod}} & start_sod) | reach;
  assign report = active & rep_mask;
  assign report_any = |report;
  always_comb begin
    state_nx = state;
    if (bus.stop) state_nx = IDLE;
    else if (bus.start && state == IDLE) state_nx = RUN;
`ifdef MON_REPORT_HALT_EN
    else if (state == RUN && report_any) state_nx = HALT;
`endif
  end
  assign go = state == IDLE && state_nx == RUN;
  assign acc = state == RUN && bus.sym_valid;
  // Only RUN updates activity and counters, so HALT and IDLE both freeze them for readout.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sod <= 1'b0;
      active <= '0;
      sym_cnt <= '0;
      rep_cnt <= '0;
      first_rep_idx <= '0;
      first_rep_vld <= 1'b0;
    end else begin
      state <= state_nx;
      if (go) begin
        sod <= 1'b1;
        active <= '0;
        sym_cnt <= '0;
        rep_cnt <= '0;
        first_rep_vld <= 1'b0;
      end else if (state == RUN) begin
        if (acc) begin
          sod <= 1'b0;
          active <= enable & match;
          if (sym_cnt != CNT_MAX) sym_cnt <= sym_cnt + 1'b1;
        end
        if (report_any && rep_cnt != CNT_MAX) rep_cnt <= rep_cnt + 1'b1;
        if (report_any && !first_rep_vld) begin
          first_rep_idx <= sym_cnt;
          first_rep_vld <= 1'b1;
        end
      end
    end
  end
  assign bus.cfg_ready = state != RUN;
  assign bus.running = state == RUN;
`ifdef MON_REPORT_HALT_EN
  assign bus.halted = state == HALT;
`else
  assign bus.halted = 1'b0;
`endif
  assign bus.active = active;
  assign bus.report = report;
  assign bus.report_any = report_any;
  assign bus.sym_cnt = sym_cnt;
  assign bus.rep_cnt = rep_cnt;
  assign bus.first_rep_idx = first_rep_idx;
  assign bus.first_rep_vld = first_rep_vld;
endmodule

// File: tb/tb_ltl_nfa_monitor_prog.sv
// tb_ltl_nfa_monitor_prog: directed checks of config gating, NFA stepping, counters and first-report capture.
module tb_ltl_nfa_monitor_prog;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int n = 0;
  int nerr = 0;
  always #5 clk = ~clk;
  ltl_nfa_monitor_prog_if #(.CNT_W(4)) b();
  ltl_nfa_monitor_prog #(.CNT_W(4)) dut (.clk(clk), .reset(reset), .bus(b.slave));
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [16:0] iv(input logic [7:0] l, input logic [7:0] h);
    return {1'b1, l, h};
  endfunction
  function automatic logic [16:0] msk(input logic [15:0] m);
    return {1'b0, m};
  endfunction
  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask
  task automatic cfg(input logic [2:0] s, input int ste, input int intv, input logic [16:0] d);
    b.cfg_valid = 1'b1;
    b.cfg_sel = s;
    b.cfg_ste = ste[3:0];
    b.cfg_intv = intv[1:0];
    b.cfg_data = d;
    tick();
    b.cfg_valid = 1'b0;
  endtask
  task automatic pulse_start();
    b.start = 1'b1;
    tick();
    b.start = 1'b0;
  endtask
  task automatic pulse_stop();
    b.stop = 1'b1;
    tick();
    b.stop = 1'b0;
  endtask
  task automatic send(input logic [7:0] s);
    b.sym_valid = 1'b1;
    b.sym = s;
    tick();
    b.sym_valid = 1'b0;
  endtask
  initial begin
    b.cfg_valid = 0; b.cfg_sel = 0; b.cfg_ste = 0; b.cfg_intv = 0; b.cfg_data = 0;
    b.start = 0; b.stop = 0; b.sym_valid = 0; b.sym = 0;
    do_reset();
    chk("rst_cfg_ready", b.cfg_ready, 1);
    chk("rst_running", b.running, 0);
    chk("rst_halted", b.halted, 0);
    chk("rst_active", b.active, 0);
    chk("rst_report_any", b.report_any, 0);
    chk("rst_sym_cnt", b.sym_cnt, 0);
    chk("rst_rep_cnt", b.rep_cnt, 0);
    chk("rst_first_vld", b.first_rep_vld, 0);
    // config gating: a write held during RUN must only land after stop
    cfg(0, 0, 0, iv(8'h00, 8'h0F));
    cfg(3, 0, 0, msk(16'h0001));
    pulse_start();
    chk("gate_running", b.running, 1);
    chk("gate_ready_run", b.cfg_ready, 0);
    b.cfg_valid = 1'b1; b.cfg_sel = 0; b.cfg_ste = 0; b.cfg_intv = 0; b.cfg_data = iv(8'h20, 8'h2F);
    tick();
    send(8'h05);
    chk("gate_old_cfg", b.active, 16'h0001);
    pulse_stop();
    chk("gate_ready_idle", b.cfg_ready, 1);
    chk("gate_idle_hold", b.active, 16'h0001);
    tick();
    b.cfg_valid = 1'b0;
    pulse_start();
    chk("gate_start_clr", b.active, 0);
    send(8'h05);
    chk("gate_new_cfg_miss", b.active, 0);
    send(8'h25);
    chk("gate_new_cfg_hit", b.active, 16'h0001);
    chk("gate_sym_cnt", b.sym_cnt, 2);
    // start-of-data only activates on the first symbol
    do_reset();
    chk("sod_cfg_cleared", b.active, 0);
    cfg(0, 0, 0, iv(8'h00, 8'h0F));
    cfg(2, 0, 0, msk(16'h0001));
    cfg(4, 0, 0, msk(16'h0001));
    pulse_start();
    send(8'h05);
    chk("sod_act1", b.active, 16'h0001);
    chk("sod_report1", b.report, 16'h0001);
    send(8'h05);
    chk("sod_act2", b.active, 0);
    tick();
    chk("sod_rep_cnt", b.rep_cnt, 1);
    chk("sod_first_vld", b.first_rep_vld, 1);
    chk("sod_first_idx", b.first_rep_idx, 1);
    pulse_stop();
    // two-step chain STE0 -> STE1
    do_reset();
    cfg(0, 0, 0, iv(8'h00, 8'h0F));
    cfg(3, 0, 0, msk(16'h0001));
    cfg(1, 0, 0, msk(16'h0002));
    cfg(0, 1, 0, iv(8'h10, 8'h1F));
    cfg(4, 0, 0, msk(16'h0002));
    pulse_start();
    send(8'h03);
    chk("chain_act1", b.active, 16'h0001);
    chk("chain_rep1", b.report_any, 0);
    send(8'h12);
    chk("chain_act2", b.active, 16'h0002);
    chk("chain_rep2", b.report, 16'h0002);
`ifdef MON_REPORT_HALT_EN
    tick();
    chk("halt_halted", b.halted, 1);
    chk("halt_ready", b.cfg_ready, 1);
    send(8'h03);
    chk("halt_act_frozen", b.active, 16'h0002);
    chk("halt_cnt_frozen", b.sym_cnt, 2);
`else
    send(8'h12);
    chk("chain_act3", b.active, 0);
    chk("chain_rep3", b.report_any, 0);
    chk("chain_sym_cnt", b.sym_cnt, 3);
`endif
    tick();
    chk("chain_first_idx", b.first_rep_idx, 2);
    chk("chain_first_vld", b.first_rep_vld, 1);
    chk("chain_rep_cnt", b.rep_cnt, 1);
    pulse_stop();
    chk("chain_stop_halted", b.halted, 0);
    chk("chain_stop_running", b.running, 0);
    // self-loop over two intervals, inclusive bounds
    do_reset();
    cfg(0, 2, 0, iv(8'h40, 8'h4F));
    cfg(0, 2, 1, iv(8'hC0, 8'hCF));
    cfg(0, 2, 2, iv(8'h58, 8'h50));
    cfg(1, 2, 0, msk(16'h0004));
    cfg(2, 0, 0, msk(16'h0004));
    pulse_start();
    send(8'h40);
    chk("loop_act1", b.active, 16'h0004);
    send(8'hCF);
    chk("loop_act2", b.active, 16'h0004);
    send(8'h55);
    chk("loop_lo_gt_hi", b.active, 0);
    chk("loop_sym_cnt", b.sym_cnt, 3);
    pulse_stop();
    // saturation with 4-bit counters
    do_reset();
    cfg(0, 3, 0, iv(8'h00, 8'hFF));
    cfg(3, 0, 0, msk(16'h0008));
    cfg(4, 0, 0, msk(16'h0008));
    pulse_start();
    for (int i = 0; i < 20; i++) send(8'(i * 13));
`ifdef MON_REPORT_HALT_EN
    chk("sat_sym_cnt", b.sym_cnt, 2);
    chk("sat_rep_cnt", b.rep_cnt, 1);
`else
    chk("sat_sym_cnt", b.sym_cnt, 15);
    chk("sat_rep_cnt", b.rep_cnt, 15);
`endif
    chk("sat_first_idx", b.first_rep_idx, 1);
    pulse_stop();
    b.start = 1'b1;
    b.stop = 1'b1;
    tick();
    b.start = 1'b0;
    b.stop = 1'b0;
    chk("stop_wins", b.running, 0);
    chk("idle_keeps_cnt", b.first_rep_vld, 1);
    $display("== %0d vectors applied, %0d miscompares ==", n, nerr);
    $finish;
  end
endmodule
